video_timing_gen: RTL and testbench

//  Raster timing generator for the 720p HDMI path. Produces the raw pixel/line counters
//  x1/y1 and frameWidth/frameHeight consumed by gen_video, plus hsync/vsync/de for the

---
 rtl/video_timing_gen.sv | 130 +++++++++++++
 tb/tb_video_timing_gen.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: x/y pixel counters with decodes taken from the next counter
// state, and a ce-gated delay line on hsync/vsync/de to match downstream pixel latency.
module video_timing_gen #(
  parameter int VIDEO_X_BITWIDTH = 12,
  parameter int VIDEO_Y_BITWIDTH = 11,
  parameter int H_ACTIVE         = 1280,
  parameter int H_FP             = 110,
  parameter int H_SYNC           = 40,
  parameter int H_BP             = 220,
  parameter int V_ACTIVE         = 720,
  parameter int V_FP             = 5,
  parameter int V_SYNC           = 5,
  parameter int V_BP             = 20,
  parameter bit HS_POL           = 1'b1,
  parameter bit VS_POL           = 1'b1,
  parameter int PIPE_DLY         = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ce,
  output logic [VIDEO_X_BITWIDTH-1:0] x1,
  output logic [VIDEO_Y_BITWIDTH-1:0] y1,
  output logic [VIDEO_X_BITWIDTH-1:0] frameWidth,
  output logic [VIDEO_Y_BITWIDTH-1:0] frameHeight,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        de,
  output logic                        line_start,
  output logic                        frame_start,
  output logic [7:0]                  frame_count
);
  localparam int XW      = VIDEO_X_BITWIDTH;
  localparam int YW      = VIDEO_Y_BITWIDTH;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEG = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_BEG = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END = YW'(V_ACTIVE + V_FP + V_SYNC);

  // {de, hsync, vsync} levels outside active/sync regions
  localparam logic [2:0] SIG_IDLE = {1'b0, ~HS_POL, ~VS_POL};

  generate
    if (H_TOTAL >= (1 << VIDEO_X_BITWIDTH)) begin : g_h_too_wide
      $error("video_timing_gen: H_TOTAL does not fit in VIDEO_X_BITWIDTH");
    end
    if (V_TOTAL >= (1 << VIDEO_Y_BITWIDTH)) begin : g_v_too_wide
      $error("video_timing_gen: V_TOTAL does not fit in VIDEO_Y_BITWIDTH");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_dly_range
      $error("video_timing_gen: PIPE_DLY must be 0..7");
    end
  endgenerate

  logic [XW-1:0]             x_q, x_d;
  logic [YW-1:0]             y_q, y_d;
  logic [7:0]                fc_q, fc_d;
  logic                      primed_q;
  logic                      ls_q, fs_q;
  logic [2:0]                raw_d;
  logic [3*(PIPE_DLY+1)-1:0] dly_q, dly_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    fc_d = fc_q;
    if (ce) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        if (y_q == V_LAST) begin
          y_d = '0;
          // the wrap out of the reset position opens frame 0 rather than closing one
          if (primed_q) fc_d = fc_q + 8'd1;
        end else begin
          y_d = y_q + YW'(1);
        end
      end else begin
        x_d = x_q + XW'(1);
      end
    end
    raw_d[2] = (x_d < H_ACT) && (y_d < V_ACT);
    raw_d[1] = ((x_d >= HS_BEG) && (x_d < HS_END)) ? HS_POL : ~HS_POL;
    raw_d[0] = ((y_d >= VS_BEG) && (y_d < VS_END)) ? VS_POL : ~VS_POL;
  end

  // Slot 0 holds the decode of the current x1/y1; each further slot is one ce older.
  generate
    if (PIPE_DLY == 0) begin : g_no_dly
      assign dly_d = raw_d;
    end else begin : g_dly
      assign dly_d = {dly_q[3*PIPE_DLY-1:0], raw_d};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= H_LAST;
      y_q      <= V_LAST;
      fc_q     <= '0;
      primed_q <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
      dly_q    <= {(PIPE_DLY+1){SIG_IDLE}};
    end else if (ce) begin
      x_q      <= x_d;
      y_q      <= y_d;
      fc_q     <= fc_d;
      primed_q <= 1'b1;
      ls_q     <= (x_d == '0);
      fs_q     <= (x_d == '0) && (y_d == '0);
      dly_q    <= dly_d;
    end
  end

  assign x1                 = x_q;
  assign y1                 = y_q;
  assign frameWidth         = XW'(H_TOTAL);
  assign frameHeight        = YW'(V_TOTAL);
  assign line_start         = ls_q;
  assign frame_start        = fs_q;
  assign frame_count        = fc_q;
  assign {de, hsync, vsync} = dly_q[3*PIPE_DLY +: 3];

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: one default 720p instance plus three reduced-raster builds
// (PIPE_DLY 0/1/3, one with inverted sync polarity) checked against an index-based model.
module tb_video_timing_gen;
  localparam int PHA[4] = '{1280, 8, 8, 8};
  localparam int PHF[4] = '{110, 2, 2, 2};
  localparam int PHS[4] = '{40, 3, 3, 3};
  localparam int PHB[4] = '{220, 4, 4, 4};
  localparam int PVA[4] = '{720, 6, 6, 6};
  localparam int PVF[4] = '{5, 1, 1, 1};
  localparam int PVS[4] = '{5, 2, 2, 2};
  localparam int PVB[4] = '{20, 2, 2, 2};
  localparam bit PHP[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  localparam bit PVP[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  localparam int PDL[4] = '{1, 0, 1, 3};

  typedef struct {
    int x;
    int y;
    bit de;
    bit hs;
    bit vs;
    bit ls;
    bit fs;
    int fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;
  logic [11:0] ox[4];
  logic [11:0] ofw[4];
  logic [10:0] oy[4];
  logic [10:0] ofh[4];
  logic        ohs[4], ovs[4], ode[4], ols[4], ofs[4];
  logic [7:0]  ofc[4];

  int     checks   = 0;
  int     failures = 0;
  longint n        = 0;

  always #5 clk = ~clk;

  video_timing_gen u_dut0 (
    .clk(clk), .rst(rst), .ce(ce), .x1(ox[0]), .y1(oy[0]),
    .frameWidth(ofw[0]), .frameHeight(ofh[0]), .hsync(ohs[0]), .vsync(ovs[0]),
    .de(ode[0]), .line_start(ols[0]), .frame_start(ofs[0]), .frame_count(ofc[0])
  );

  generate
    for (genvar g = 1; g < 4; g++) begin : g_small
      video_timing_gen #(
        .VIDEO_X_BITWIDTH(12), .VIDEO_Y_BITWIDTH(11),
        .H_ACTIVE(PHA[g]), .H_FP(PHF[g]), .H_SYNC(PHS[g]), .H_BP(PHB[g]),
        .V_ACTIVE(PVA[g]), .V_FP(PVF[g]), .V_SYNC(PVS[g]), .V_BP(PVB[g]),
        .HS_POL(PHP[g]), .VS_POL(PVP[g]), .PIPE_DLY(PDL[g])
      ) u_dut (
        .clk(clk), .rst(rst), .ce(ce), .x1(ox[g]), .y1(oy[g]),
        .frameWidth(ofw[g]), .frameHeight(ofh[g]), .hsync(ohs[g]), .vsync(ovs[g]),
        .de(ode[g]), .line_start(ols[g]), .frame_start(ofs[g]), .frame_count(ofc[g])
      );
    end
  endgenerate

  // Raster position is (steps - 1) mod frame size; the reset position is index -1.
  function automatic exp_t model(input int k, input longint nn);
    exp_t   e;
    int     ht, vt, mx, my;
    longint tot, idx, m, mi;
    ht   = PHA[k] + PHF[k] + PHS[k] + PHB[k];
    vt   = PVA[k] + PVF[k] + PVS[k] + PVB[k];
    tot  = longint'(ht) * vt;
    idx  = (nn + tot - 1) % tot;
    e.x  = int'(idx % ht);
    e.y  = int'(idx / ht);
    e.ls = (e.x == 0);
    e.fs = (idx == 0);
    e.fc = (nn == 0) ? 0 : int'(((nn - 1) / tot) % 256);
    e.de = 1'b0;
    e.hs = !PHP[k];
    e.vs = !PVP[k];
    m = nn - PDL[k];
    if (m >= 1) begin
      mi = (m - 1) % tot;
      mx = int'(mi % ht);
      my = int'(mi / ht);
      e.de = (mx < PHA[k]) && (my < PVA[k]);
      if (mx >= PHA[k] + PHF[k] && mx < PHA[k] + PHF[k] + PHS[k]) e.hs = PHP[k];
      if (my >= PVA[k] + PVF[k] && my < PVA[k] + PVF[k] + PVS[k]) e.vs = PVP[k];
    end
    return e;
  endfunction

  task automatic step(input bit c, input bit r);
    ce  = c;
    rst = r;
    @(posedge clk);
    if (r) n = 0;
    else if (c) n++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    checks++;
    if (ox[0] !== 12'd1649 || oy[0] !== 11'd749) begin
      failures++;
      $display("FAIL reset_xy got x=%0d y=%0d want x=1649 y=749", ox[0], oy[0]);
    end
    checks++;
    if ({ode[0], ohs[0], ovs[0], ols[0], ofs[0], ofc[0]} !== 13'b0) begin
      failures++;
      $display("FAIL reset_outs got de=%b hs=%b vs=%b ls=%b fs=%b fc=%0d want all 0",
               ode[0], ohs[0], ovs[0], ols[0], ofs[0], ofc[0]);
    end
    checks++;
    if ({ode[3], ohs[3], ovs[3]} !== 3'b011) begin
      failures++;
      $display("FAIL reset_neg_pol got de/hs/vs=%b%b%b want 011", ode[3], ohs[3], ovs[3]);
    end
    checks++;
    if (ofw[0] !== 12'd1650 || ofh[0] !== 11'd750 || ofw[2] !== 12'd17 || ofh[2] !== 11'd11) begin
      failures++;
      $display("FAIL frame_dims got %0dx%0d / %0dx%0d want 1650x750 / 17x11",
               ofw[0], ofh[0], ofw[2], ofh[2]);
    end
    step(1'b1, 1'b0);
    checks++;
    if (ox[0] !== 12'd0 || oy[0] !== 11'd0 || ofs[0] !== 1'b1 || ols[0] !== 1'b1 || ode[0] !== 1'b0) begin
      failures++;
      $display("FAIL first_ce got x=%0d y=%0d fs=%b ls=%b de=%b want 0 0 1 1 0",
               ox[0], oy[0], ofs[0], ols[0], ode[0]);
    end
    checks++;
    if (ode[1] !== 1'b1) begin
      failures++;
      $display("FAIL dly0_de got de=%b want 1", ode[1]);
    end
    step(1'b1, 1'b0);
    checks++;
    if (ode[0] !== 1'b1 || ox[0] !== 12'd1 || ofs[0] !== 1'b0) begin
      failures++;
      $display("FAIL second_ce got de=%b x=%0d fs=%b want 1 1 0", ode[0], ox[0], ofs[0]);
    end
    step(1'b0, 1'b0);
    checks++;
    if (ode[3] !== 1'b0 || ox[0] !== 12'd1) begin
      failures++;
      $display("FAIL hold_ce0 got de3=%b x=%0d want 0 1", ode[3], ox[0]);
    end
    step(1'b1, 1'b0);
    checks++;
    if (ode[3] !== 1'b0) begin
      failures++;
      $display("FAIL dly3_early got de=%b want 0", ode[3]);
    end
    step(1'b1, 1'b0);
    checks++;
    if (ode[3] !== 1'b1) begin
      failures++;
      $display("FAIL dly3_rise got de=%b want 1", ode[3]);
    end
  endtask

  task automatic test_line();
    int de_cnt = 0, hs_cnt = 0, rise_px = -1, ls_first = -1, ls_second = -1;
    int x_prev;
    bit hs_prev;
    step(1'b1, 1'b1);
    x_prev  = int'(ox[0]);
    hs_prev = ohs[0];
    for (int s = 1; s <= 1651; s++) begin
      step(1'b1, 1'b0);
      if (s <= 1650 && ode[0] === 1'b1) de_cnt++;
      if (ohs[0] === 1'b1) hs_cnt++;
      if (ohs[0] === 1'b1 && hs_prev === 1'b0 && rise_px < 0) rise_px = x_prev;
      if (ols[0] === 1'b1) begin
        if (ls_first < 0) ls_first = s;
        else if (ls_second < 0) ls_second = s;
      end
      x_prev  = int'(ox[0]);
      hs_prev = ohs[0];
    end
    checks++;
    if (de_cnt != 1280) begin
      failures++;
      $display("FAIL line_de_count got %0d want 1280", de_cnt);
    end
    checks++;
    if (rise_px != 1390) begin
      failures++;
      $display("FAIL hsync_rise got prev_x=%0d want 1390", rise_px);
    end
    checks++;
    if (hs_cnt != 40) begin
      failures++;
      $display("FAIL hsync_width got %0d want 40", hs_cnt);
    end
    checks++;
    if (ls_first != 1 || ls_second - ls_first != 1650) begin
      failures++;
      $display("FAIL line_period got first=%0d gap=%0d want 1 1650", ls_first, ls_second - ls_first);
    end
  endtask

  task automatic test_frame();
    int cnt = 0, vs_cnt = 0, vx = -1, vy = -1;
    int x_prev, y_prev;
    bit vs_prev, found = 1'b0;
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    x_prev  = int'(ox[2]);
    y_prev  = int'(oy[2]);
    vs_prev = ovs[2];
    for (int s = 0; s < 400 && !found; s++) begin
      step(1'b1, 1'b0);
      cnt++;
      if (ovs[2] === 1'b1) vs_cnt++;
      if (ovs[2] === 1'b1 && vs_prev === 1'b0 && vx < 0) begin
        vx = x_prev;
        vy = y_prev;
      end
      if (ofs[2] === 1'b1) found = 1'b1;
      x_prev  = int'(ox[2]);
      y_prev  = int'(oy[2]);
      vs_prev = ovs[2];
    end
    checks++;
    if (!found || cnt != 187 || ofc[2] !== 8'd1) begin
      failures++;
      $display("FAIL frame_wrap got found=%0d steps=%0d fc=%0d want 1 187 1", found, cnt, ofc[2]);
    end
    checks++;
    if (vx != 0 || vy != 7 || vs_cnt != 34) begin
      failures++;
      $display("FAIL vsync_window got prev=(%0d,%0d) width=%0d want (0,7) 34", vx, vy, vs_cnt);
    end
  endtask

  task automatic test_ce_toggle();
    int ls_first = -1, ls_second = -1, hs_cnt = 0, bad = 0;
    bit ls_prev;
    exp_t e;
    step(1'b1, 1'b1);
    ls_prev = ols[0];
    for (int c = 0; c < 3400; c++) begin
      step((c % 2) == 0, 1'b0);
      if (ols[0] === 1'b1 && ls_prev === 1'b0) begin
        if (ls_first < 0) ls_first = c;
        else if (ls_second < 0) ls_second = c;
      end
      if (c < 3300 && ohs[0] === 1'b1) hs_cnt++;
      ls_prev = ols[0];
      if ((c % 2) == 1 && bad < 5) begin
        e = model(0, n);
        checks++;
        if ({ox[0], oy[0], ode[0], ohs[0], ovs[0], ols[0], ofs[0]} !==
            {e.x[11:0], e.y[10:0], e.de, e.hs, e.vs, e.ls, e.fs}) begin
          failures++;
          bad++;
          $display("FAIL ce0_hold c=%0d got x=%0d y=%0d de=%b hs=%b want x=%0d y=%0d de=%b hs=%b",
                   c, ox[0], oy[0], ode[0], ohs[0], e.x, e.y, e.de, e.hs);
        end
      end
    end
    checks++;
    if (ls_first != 0 || ls_second - ls_first != 3300) begin
      failures++;
      $display("FAIL ce_line_period got first=%0d gap=%0d want 0 3300", ls_first, ls_second - ls_first);
    end
    checks++;
    if (hs_cnt != 80) begin
      failures++;
      $display("FAIL ce_hsync_width got %0d want 80", hs_cnt);
    end
  endtask

  task automatic test_mid_reset();
    step(1'b1, 1'b1);
    for (int s = 0; s < 501; s++) step(1'b1, 1'b0);
    checks++;
    if (ox[0] !== 12'd500 || ofc[2] !== 8'd2) begin
      failures++;
      $display("FAIL pre_reset got x=%0d fc2=%0d want 500 2", ox[0], ofc[2]);
    end
    step(1'b1, 1'b1);
    checks++;
    if (ox[0] !== 12'd1649 || oy[0] !== 11'd749 || ode[0] !== 1'b0 || ohs[0] !== 1'b0 ||
        ovs[0] !== 1'b0 || ofc[0] !== 8'd0) begin
      failures++;
      $display("FAIL mid_reset got x=%0d y=%0d de=%b hs=%b vs=%b fc=%0d want 1649 749 0 0 0 0",
               ox[0], oy[0], ode[0], ohs[0], ovs[0], ofc[0]);
    end
    checks++;
    if (ox[2] !== 12'd16 || oy[2] !== 11'd10 || ofc[2] !== 8'd0) begin
      failures++;
      $display("FAIL mid_reset_small got x=%0d y=%0d fc=%0d want 16 10 0", ox[2], oy[2], ofc[2]);
    end
    step(1'b1, 1'b0);
    checks++;
    if (ox[0] !== 12'd0 || oy[0] !== 11'd0 || ofs[0] !== 1'b1) begin
      failures++;
      $display("FAIL post_reset got x=%0d y=%0d fs=%b want 0 0 1", ox[0], oy[0], ofs[0]);
    end
  endtask

  task automatic test_random();
    exp_t e;
    logic [35:0] got, want;
    int bad = 0;
    for (int c = 0; c < 20000 && bad < 10; c++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2999) == 0);
      for (int k = 0; k < 4; k++) begin
        e = model(k, n);
        got  = {ox[k], oy[k], ode[k], ohs[k], ovs[k], ols[k], ofs[k], ofc[k]};
        want = {e.x[11:0], e.y[10:0], e.de, e.hs, e.vs, e.ls, e.fs, e.fc[7:0]};
        checks++;
        if (got !== want) begin
          failures++;
          bad++;
          $display("FAIL random k=%0d n=%0d got x=%0d y=%0d de/hs/vs/ls/fs=%b%b%b%b%b fc=%0d want x=%0d y=%0d de/hs/vs/ls/fs=%b%b%b%b%b fc=%0d",
                   k, n, ox[k], oy[k], ode[k], ohs[k], ovs[k], ols[k], ofs[k], ofc[k],
                   e.x, e.y, e.de, e.hs, e.vs, e.ls, e.fs, e.fc);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_ce_toggle();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
